// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC upsampling interpolator.
package dac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } dac_state_e;

    localparam int unsigned DAC_BW = 16;

    // Accumulator holds sample << osr_log2 plus one sign-guard bit.
    function automatic int unsigned acc_width(input int unsigned bw, input int unsigned osr_log2);
        return bw + osr_log2 + 1;
    endfunction

endpackage

// File: rtl/dac_interp_if.sv
// Sample-in / DAC-word-out bundle between the PCM producer and the interpolator.
interface dac_interp_if
    import dac_pkg::*;
#(
    parameter int unsigned BW = DAC_BW
);

    logic [BW-1:0] smp_i;
    logic          smp_valid_i;
    logic          smp_ready_o;
    logic [BW-1:0] dac_o;
    logic          underrun_o;

    modport master (
        output smp_i,
        output smp_valid_i,
        input  smp_ready_o,
        input  dac_o,
        input  underrun_o
    );

    modport slave (
        input  smp_i,
        input  smp_valid_i,
        output smp_ready_o,
        output dac_o,
        output underrun_o
    );

endinterface

// File: rtl/dac_smp_fifo.sv
// Small synchronous sample FIFO; Depth must be a power of two so pointers wrap naturally.
module dac_smp_fifo #(
    parameter  int unsigned Width = 16,
    parameter  int unsigned Depth = 2,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dac_interp.sv
// Linear upsampling interpolator feeding the delta-sigma modulator: one output word per clock,
// ramping from prev to cur over 2^OSR_LOG2 cycles, holding the last sample on starvation.
module dac_interp
    import dac_pkg::*;
#(
    parameter int unsigned BW         = DAC_BW,
    parameter int unsigned OSR_LOG2   = 6,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dac_interp_if.slave bus
);

    localparam int unsigned AccW = acc_width(BW, OSR_LOG2);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [OSR_LOG2-1:0]   ph_q;
    logic                  boundary;
    dac_state_e            state_q, state_d;
    logic signed [BW-1:0]  prev_q, prev_d, cur_q, cur_d;
    logic signed [BW:0]    delta;
    logic signed [AccW-1:0] acc_q, acc_d, delta_ext, cur_shl;
    logic                  underrun_q, underrun_d;

    logic                  ready, push, pop;
    logic [BW-1:0]         fifo_head;
    logic [CntW-1:0]       fifo_count;
    logic                  fifo_empty;
    logic                  unused_full;
    logic                  unused_acc;

    // Ready comes from the registered count only, never from this cycle's pop.
    assign ready = !rst_i && (fifo_count < CntW'(FIFO_DEPTH));
    assign push  = bus.smp_valid_i && ready;

    dac_smp_fifo #(
        .Width (BW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (bus.smp_i),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (unused_full),
        .empty (fifo_empty)
    );

    assign boundary  = &ph_q;
    assign delta     = {cur_q[BW-1], cur_q} - {prev_q[BW-1], prev_q};
    assign delta_ext = {{OSR_LOG2{delta[BW]}}, delta};
    assign cur_shl   = {cur_q[BW-1], cur_q, {OSR_LOG2{1'b0}}};

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        acc_d      = acc_q + delta_ext;
        underrun_d = underrun_q;
        pop        = 1'b0;
        if (boundary) begin
            // Restarting from cur << L keeps the ramp exact with no accumulated drift.
            prev_d = cur_q;
            acc_d  = cur_shl;
            if (!fifo_empty) begin
                pop     = 1'b1;
                cur_d   = fifo_head;
                state_d = StRun;
            end else if (state_q == StRun) begin
                state_d    = StHold;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q       <= '0;
            state_q    <= StIdle;
            prev_q     <= '0;
            cur_q      <= '0;
            acc_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            ph_q       <= ph_q + OSR_LOG2'(1);
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            underrun_q <= underrun_d;
        end
    end

    // acc always lies between prev << L and cur << L, so the top guard bit is redundant.
    assign bus.dac_o       = acc_q[OSR_LOG2 +: BW];
    assign bus.underrun_o  = underrun_q;
    assign bus.smp_ready_o = ready;
    assign unused_acc      = ^{acc_q[AccW-1], acc_q[OSR_LOG2-1:0]};

endmodule

// File: tb/tb_dac_interp.sv
// Self-checking bench for dac_interp: behavioural ramp model plus literal pins of the model.
module tb_dac_interp;

    localparam int unsigned BW    = 16;
    localparam int unsigned L     = 2;
    localparam int unsigned DEPTH = 2;
    localparam int          PER   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_interp_if #(.BW(BW)) bus ();

    dac_interp #(
        .BW         (BW),
        .OSR_LOG2   (L),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Model: queue of buffered samples, the two endpoints of the current ramp and the phase.
    int m_q[$];
    int m_prev  = 0;
    int m_cur   = 0;
    int m_ph    = 0;
    int m_state = 0;  // 0 idle, 1 run, 2 hold
    int m_under = 0;
    bit m_live  = 1'b0;
    bit m_take;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_prev  = 0;
            m_cur   = 0;
            m_ph    = 0;
            m_state = 0;
            m_under = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_take = bus.smp_valid_i && (m_q.size() < DEPTH);
            if (m_ph == PER - 1) begin
                m_prev = m_cur;
                if (m_q.size() > 0) begin
                    m_cur   = m_q.pop_front();
                    m_state = 1;
                end else if (m_state == 1) begin
                    m_state = 2;
                    m_under = 1;
                end
            end
            if (m_take) m_q.push_back(int'($signed(bus.smp_i)));
            m_ph = (m_ph + 1) % PER;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("dac", int'($signed(bus.dac_o)), m_prev + fdiv(m_ph * (m_cur - m_prev), PER));
            chk("underrun", int'(bus.underrun_o), m_under);
            chk("ready", int'(bus.smp_ready_o), (!rst && m_q.size() < DEPTH) ? 1 : 0);
        end
    end

    task automatic drive(input bit v, input int s);
        bus.smp_valid_i = v;
        bus.smp_i       = s[BW-1:0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: the first cycle after reset, ph = 0.
    task automatic reset_dut();
        drive(1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int ramp_exp[10] = '{0, 0, 0, 0, 0, 256, 512, 768, 1024, 1024};
    int edge_exp[5]  = '{32767, 16383, -1, -16385, -32768};
    int hold_exp[5]  = '{256, 320, 384, 448, 512};

    initial begin
        drive(1'b0, 0);

        // Idle after reset: no samples, output stays 0 and nothing is flagged.
        reset_dut();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (c == 0) chk("ready_post_reset", int'(bus.smp_ready_o), 1);
            if (c == 63) begin
                chk("idle_dac", int'($signed(bus.dac_o)), 0);
                chk("idle_underrun", int'(bus.underrun_o), 0);
            end
            next_cycle();
        end

        // Single sample 0x0400 then starvation.
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 'h0400);
            @(negedge clk);
            chk("ramp_dac", int'($signed(bus.dac_o)), ramp_exp[c]);
            if (c == 7) chk("ramp_underrun_pre", int'(bus.underrun_o), 0);
            if (c == 8) chk("ramp_underrun_post", int'(bus.underrun_o), 1);
            next_cycle();
        end
        drive(1'b0, 0);

        // Full-scale swing 0x7FFF -> 0x8000, no wrap-around.
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            drive(c < 2, (c == 0) ? 'h7FFF : 'h8000);
            @(negedge clk);
            if (c >= 8) chk("swing_dac", int'($signed(bus.dac_o)), edge_exp[c-8]);
            if (c >= 2 && c <= 4) chk("swing_ready", int'(bus.smp_ready_o), (c == 4) ? 1 : 0);
            next_cycle();
        end
        drive(1'b0, 0);

        // Valid held high: ready pulses once per period after each pop.
        reset_dut();
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, int'($urandom_range(0, 65535)));
            @(negedge clk);
            chk("stream_ready", int'(bus.smp_ready_o), (c < 2 || c % 4 == 0) ? 1 : 0);
            next_cycle();
        end
        drive(1'b0, 0);

        // Reset mid-period in RUN with two samples queued and underrun set.
        reset_dut();
        for (int c = 0; c < 13; c++) begin
            drive(c == 0 || c == 8 || c == 9 || c == 12,
                  (c == 0) ? 'h0100 : (c == 8) ? 'h0300 : (c == 9) ? 'h0500 : 'h0700);
            @(negedge clk);
            next_cycle();
        end
        drive(1'b0, 0);
        @(negedge clk);
        chk("pre_rst_underrun", int'(bus.underrun_o), 1);
        chk("pre_rst_ready", int'(bus.smp_ready_o), 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, 'h0040);
            @(negedge clk);
            if (c == 0) begin
                chk("post_rst_dac", int'($signed(bus.dac_o)), 0);
                chk("post_rst_underrun", int'(bus.underrun_o), 0);
                chk("post_rst_ready", int'(bus.smp_ready_o), 1);
            end
            // Phase restarted at 0, so the first ramp step lands at cycle 5.
            if (c == 5) chk("post_rst_phase", int'($signed(bus.dac_o)), 'h0010);
            next_cycle();
        end
        drive(1'b0, 0);

        // Starve three periods in HOLD, then resume ramping toward 0x0200.
        reset_dut();
        for (int c = 0; c < 29; c++) begin
            drive(c == 0 || c == 20, (c == 0) ? 'h0100 : 'h0200);
            @(negedge clk);
            if (c == 12 || c == 22) chk("hold_dac", int'($signed(bus.dac_o)), 'h0100);
            if (c >= 24) begin
                chk("resume_dac", int'($signed(bus.dac_o)), hold_exp[c-24]);
                chk("resume_underrun", int'(bus.underrun_o), 1);
            end
            next_cycle();
        end
        drive(1'b0, 0);

        // Random traffic with occasional resets, checked against the model every cycle.
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 7) < ((c / 200) % 2 == 0 ? 2 : 6),
                  int'($urandom_range(0, 65535)));
            rst = ($urandom_range(0, 99) == 0);
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b0, 0);
        repeat (8) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
